imm_packer: RTL

- Inverse of the immediate generator: scatters a 32-bit immediate value into the immediate bit fields of a RISC-V instruction word.
- Selected by the same ImmSrc encoding the datapath uses.
- Sits in the program loader / debug instruction-injection path, so software-supplied constants become legal RV32I encodings.
- Valid/ready stream in and out, one registered output stage, range and alignment checking.

---
 rtl/imm_packer_pkg.sv | 19 +
 rtl/imm_packer_if.sv | 24 ++
 rtl/imm_pack_field.sv | 53 +++++
 rtl/imm_packer.sv | 107 ++++++++++
 4 files changed

// File: rtl/imm_packer_pkg.sv
// Shared encodings for the immediate packer, generator and decoder.
package imm_packer_pkg;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_U  = 3'b010;
  localparam logic [2:0] IMM_LI = 3'b011;
  localparam logic [2:0] IMM_B  = 3'b101;
  localparam logic [2:0] IMM_J  = 3'b110;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  typedef enum logic [0:0] {
    StIdle,
    StEmit2
  } state_e;

endpackage

// File: rtl/imm_packer_if.sv
// Request/response stream bundle of the immediate packer.
interface imm_packer_if;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [31:0] imm_val;
  logic [31:0] instr_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        out_err;

  modport master (
    output in_valid, ImmSrc, imm_val, instr_base, out_ready,
    input  in_ready, out_valid, instr, out_err
  );

  modport slave (
    input  in_valid, ImmSrc, imm_val, instr_base, out_ready,
    output in_ready, out_valid, instr, out_err
  );

endinterface

// File: rtl/imm_pack_field.sv
// Combinational scatter of an immediate into RV32I instruction fields, with range check.
module imm_pack_field
  import imm_packer_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  // An immediate fits an N-bit signed field when all bits above N-2 match the sign.
  logic fits12, fits13, fits21;
  assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    word_o = base_i;
    err_o  = 1'b0;
    case (imm_src_i)
      IMM_I: begin
        word_o[31:20] = imm_i[11:0];
        err_o         = ~fits12;
      end
      IMM_S: begin
        word_o[31:25] = imm_i[11:5];
        word_o[11:7]  = imm_i[4:0];
        err_o         = ~fits12;
      end
      IMM_B: begin
        word_o[31]    = imm_i[12];
        word_o[30:25] = imm_i[10:5];
        word_o[11:8]  = imm_i[4:1];
        word_o[7]     = imm_i[11];
        err_o         = ~fits13 | imm_i[0];
      end
      IMM_U: begin
        word_o[31:12] = imm_i[31:12];
        err_o         = |imm_i[11:0];
      end
      IMM_J: begin
        word_o[31]    = imm_i[20];
        word_o[30:21] = imm_i[10:1];
        word_o[20]    = imm_i[11];
        word_o[19:12] = imm_i[19:12];
        err_o         = ~fits21 | imm_i[0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_packer.sv
// Immediate packer: stream handshake and output register around imm_pack_field.
// Define IMM_PACKER_LI_SPLIT_EN to expand ImmSrc=011 (LI) into LUI + ADDI.
module imm_packer
  import imm_packer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst,
  imm_packer_if.slave bus
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic            out_valid_q, out_valid_d;
  logic            err_q, err_d;
  logic [31:0]     field_word;
  logic            field_err;
  logic            accept;

  imm_pack_field u_field (
    .imm_src_i (bus.ImmSrc),
    .imm_i     (bus.imm_val),
    .base_i    (bus.instr_base),
    .word_o    (field_word),
    .err_o     (field_err)
  );

`ifdef IMM_PACKER_LI_SPLIT_EN
  state_e      state_q, state_d;
  logic [11:0] lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;
  logic [19:0] li_hi;

  // (imm + 0x800) >> 12 without a full-width adder: the carry out of the low 12 bits is imm[11].
  assign li_hi        = bus.imm_val[31:12] + {19'b0, bus.imm_val[11]};
  assign bus.in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.out_err   = err_q;

  always_comb begin
    instr_d     = instr_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
`ifdef IMM_PACKER_LI_SPLIT_EN
    state_d = state_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = field_word;
      err_d       = field_err;
`ifdef IMM_PACKER_LI_SPLIT_EN
      if (bus.ImmSrc == IMM_LI) begin
        instr_d = {li_hi, bus.instr_base[11:7], OP_LUI};
        err_d   = 1'b0;
        lo_d    = bus.imm_val[11:0];
        rd_d    = bus.instr_base[11:7];
        if (|bus.imm_val[11:0]) begin
          state_d = StEmit2;
        end
      end
`endif
    end else if (out_valid_q && bus.out_ready) begin
`ifdef IMM_PACKER_LI_SPLIT_EN
      if (state_q == StEmit2) begin
        instr_d = {lo_q, rd_q, 3'b000, rd_q, OP_OPIMM};
        err_d   = 1'b0;
        state_d = StIdle;
      end else begin
        out_valid_d = 1'b0;
      end
`else
      out_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef IMM_PACKER_LI_SPLIT_EN
      state_q <= StIdle;
      lo_q    <= '0;
      rd_q    <= '0;
`endif
    end else begin
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
`ifdef IMM_PACKER_LI_SPLIT_EN
      state_q <= state_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
`endif
    end
  end

endmodule
